vram_slot_arbiter: RTL and testbench

//  Shares the single VRAM port between display fetch, sprite engine and CPU using the
//  5-cycle serial-clock slot structure (5 serial clocks per pixel clock). Exactly one

---
 rtl/vram_slot_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter
//   Shares one VRAM port between display fetch, sprite engine and CPU. Each
//   pixel period is 5 serial clocks. At most one access is granted per
//   period, and only in the cycle where I_phase_0 is high.
//
//   Timeline of one access (T0 = grant cycle):
//     T0             ack (combinational), request fields are registered
//     T1             O_mem_ce with the registered addr/we/wdata
//     T1+RD_LATENCY  I_mem_rdata captured at the end of this cycle (reads)
//     T2+RD_LATENCY  owner's rvalid pulse, rdata updated and held
//
//   Ports
//     O_serial_clk, O_N_reset    serial clock, async active-low reset
//     I_phase_0                  phase-0 marker from the phase generator
//     I/O_disp_*, I/O_spr_*      read-only requesters (level req, 1-cycle ack)
//     I/O_cpu_*                  read/write requester
//     O_mem_*, I_mem_rdata       VRAM interface
//     O_phase_err                phase-0 seen while the internal phase != 0
module vram_slot_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic              O_serial_clk,
  input  logic              O_N_reset,
  input  logic              I_phase_0,
  input  logic              I_disp_req,
  input  logic [ADDR_W-1:0] I_disp_addr,
  output logic              O_disp_ack,
  output logic              O_disp_rvalid,
  output logic [DATA_W-1:0] O_disp_rdata,
  input  logic              I_spr_req,
  input  logic [ADDR_W-1:0] I_spr_addr,
  output logic              O_spr_ack,
  output logic              O_spr_rvalid,
  output logic [DATA_W-1:0] O_spr_rdata,
  input  logic              I_cpu_req,
  input  logic              I_cpu_we,
  input  logic [ADDR_W-1:0] I_cpu_addr,
  input  logic [DATA_W-1:0] I_cpu_wdata,
  output logic              O_cpu_ack,
  output logic              O_cpu_rvalid,
  output logic [DATA_W-1:0] O_cpu_rdata,
  output logic              O_mem_ce,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_wdata,
  input  logic [DATA_W-1:0] I_mem_rdata,
  output logic              O_phase_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  localparam logic [1:0] OWN_DISP  = 2'd0;
  localparam logic [1:0] OWN_SPR   = 2'd1;
  localparam logic [1:0] OWN_CPU   = 2'd2;
  localparam logic [1:0] WCNT_INIT = 2'(RD_LATENCY - 1);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_ph;
  logic              r_synced;
  logic              r_rr_cpu;     // 1: CPU wins a sprite/CPU tie
  logic [1:0]        r_wcnt;
  logic [1:0]        r_owner;
  logic              r_is_rd;
  logic              r_mem_ce, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_disp_rvalid, r_spr_rvalid, r_cpu_rvalid;
  logic [DATA_W-1:0] r_disp_rdata, r_spr_rdata, r_cpu_rdata;

  logic              w_arb, w_g_disp, w_g_spr, w_g_cpu, w_grant, w_cpu_wr;
  logic              w_cap;
  logic [ADDR_W-1:0] w_addr;

  // Arbitration window. Reset gating keeps the combinational acks at 0 while
  // the block is held in reset.
  assign w_arb    = I_phase_0 & O_N_reset & (r_state == S_IDLE);
  assign w_g_disp = w_arb & I_disp_req;
  assign w_g_cpu  = w_arb & ~I_disp_req & I_cpu_req & (r_rr_cpu | ~I_spr_req);
  assign w_g_spr  = w_arb & ~I_disp_req & I_spr_req & (~r_rr_cpu | ~I_cpu_req);
  assign w_grant  = w_g_disp | w_g_spr | w_g_cpu;
  assign w_cpu_wr = w_g_cpu & I_cpu_we;
  assign w_addr   = w_g_disp ? I_disp_addr : (w_g_spr ? I_spr_addr : I_cpu_addr);

  assign O_disp_ack  = w_g_disp;
  assign O_spr_ack   = w_g_spr;
  assign O_cpu_ack   = w_g_cpu;
  assign O_phase_err = I_phase_0 & r_synced & (r_ph != 3'd0);

  // FSM next state; w_cap marks the cycle whose end carries valid read data.
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE:    if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = r_is_rd ? S_WAIT : S_IDLE;
      S_WAIT:    if (r_wcnt == 2'd0) begin
                   w_state_nxt = S_DELIVER;
                   w_cap       = 1'b1;
                 end
      S_DELIVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge O_serial_clk or negedge O_N_reset) begin
    if (!O_N_reset) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Phase tracking: I_phase_0 marks phase 0, so the following cycle is phase 1.
  always_ff @(posedge O_serial_clk or negedge O_N_reset) begin
    if (!O_N_reset) begin
      r_ph     <= 3'd0;
      r_synced <= 1'b0;
    end else begin
      if (I_phase_0)           r_ph <= 3'd1;
      else if (r_ph == 3'd4)   r_ph <= 3'd0;
      else                     r_ph <= r_ph + 3'd1;
      if (I_phase_0) r_synced <= 1'b1;
    end
  end

  // Access launch, wait counter and round-robin pointer.
  always_ff @(posedge O_serial_clk or negedge O_N_reset) begin
    if (!O_N_reset) begin
      r_rr_cpu    <= 1'b1;
      r_wcnt      <= 2'd0;
      r_owner     <= OWN_DISP;
      r_is_rd     <= 1'b0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      // mem outputs are zero except in the single strobe cycle
      r_mem_ce    <= w_grant;
      r_mem_we    <= w_cpu_wr;
      r_mem_addr  <= w_grant ? w_addr : '0;
      r_mem_wdata <= w_cpu_wr ? I_cpu_wdata : '0;
      if (w_grant) begin
        r_owner <= w_g_disp ? OWN_DISP : (w_g_spr ? OWN_SPR : OWN_CPU);
        r_is_rd <= ~w_cpu_wr;
      end
      if (w_g_cpu)      r_rr_cpu <= 1'b0;
      else if (w_g_spr) r_rr_cpu <= 1'b1;
      if (r_state == S_ISSUE)                      r_wcnt <= WCNT_INIT;
      else if (r_state == S_WAIT && r_wcnt != 2'd0) r_wcnt <= r_wcnt - 2'd1;
    end
  end

  // Read return: data captured into the owner's holding register.
  always_ff @(posedge O_serial_clk or negedge O_N_reset) begin
    if (!O_N_reset) begin
      r_disp_rvalid <= 1'b0;
      r_spr_rvalid  <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_disp_rdata  <= '0;
      r_spr_rdata   <= '0;
      r_cpu_rdata   <= '0;
    end else begin
      r_disp_rvalid <= w_cap & (r_owner == OWN_DISP);
      r_spr_rvalid  <= w_cap & (r_owner == OWN_SPR);
      r_cpu_rvalid  <= w_cap & (r_owner == OWN_CPU);
      if (w_cap && r_owner == OWN_DISP) r_disp_rdata <= I_mem_rdata;
      if (w_cap && r_owner == OWN_SPR)  r_spr_rdata  <= I_mem_rdata;
      if (w_cap && r_owner == OWN_CPU)  r_cpu_rdata  <= I_mem_rdata;
    end
  end

  assign O_mem_ce      = r_mem_ce;
  assign O_mem_we      = r_mem_we;
  assign O_mem_addr    = r_mem_addr;
  assign O_mem_wdata   = r_mem_wdata;
  assign O_disp_rvalid = r_disp_rvalid;
  assign O_spr_rvalid  = r_spr_rvalid;
  assign O_cpu_rvalid  = r_cpu_rvalid;
  assign O_disp_rdata  = r_disp_rdata;
  assign O_spr_rdata   = r_spr_rdata;
  assign O_cpu_rdata   = r_cpu_rdata;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Testbench for vram_slot_arbiter: directed scenarios with literal
// expectations, then randomized traffic. A cycle-scheduled model checks
// every output on every cycle.
module tb_vram_slot_arbiter;
  localparam int AW = 14, DW = 8, RDL = 2;

  logic clk = 1'b0, rst_n = 1'b0, p0 = 1'b0;
  logic disp_req = 0, spr_req = 0, cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] disp_addr = '0, spr_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, mem_rdata = '0;
  logic d_ack, s_ack, c_ack, d_rv, s_rv, c_rv, m_ce, m_we, p_err;
  logic [DW-1:0] d_rd, s_rd, c_rd, m_wd;
  logic [AW-1:0] m_ad;

  always #5 clk = ~clk;

  vram_slot_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
    .O_serial_clk(clk), .O_N_reset(rst_n), .I_phase_0(p0),
    .I_disp_req(disp_req), .I_disp_addr(disp_addr), .O_disp_ack(d_ack),
    .O_disp_rvalid(d_rv), .O_disp_rdata(d_rd),
    .I_spr_req(spr_req), .I_spr_addr(spr_addr), .O_spr_ack(s_ack),
    .O_spr_rvalid(s_rv), .O_spr_rdata(s_rd),
    .I_cpu_req(cpu_req), .I_cpu_we(cpu_we), .I_cpu_addr(cpu_addr),
    .I_cpu_wdata(cpu_wdata), .O_cpu_ack(c_ack), .O_cpu_rvalid(c_rv),
    .O_cpu_rdata(c_rd), .O_mem_ce(m_ce), .O_mem_we(m_we), .O_mem_addr(m_ad),
    .O_mem_wdata(m_wd), .I_mem_rdata(mem_rdata), .O_phase_err(p_err));

  int n_chk = 0, n_err = 0, cyc = 0;
  bit rnd = 0, rnd_rdata = 1;
  bit sa_d, sa_s, sa_c;   // DUT acks seen in the previous cycle (stimulus only)

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {d_ack, s_ack, c_ack, d_rv, s_rv, c_rv, d_rd, s_rd, c_rd,
            m_ce, m_we, m_ad, m_wd, p_err};
  endfunction

  // ---------------- model: one access at a time, scheduled by cycle number
  bit seen, rr_cpu;
  int last_p0, free_cyc, ce_cyc, cap_cyc, dlv_cyc, m_own;
  logic [AW-1:0] e_addr;
  logic e_we;
  logic [DW-1:0] e_wdata, cap_data;
  logic [DW-1:0] e_rd [3];

  always @(negedge clk) begin : cmp
    int win;
    logic e_err, e_ce;
    logic [2:0] e_rv;
    if (!rst_n) begin
      chk("reset_outputs", all_out(), 64'd0);
      seen = 0; rr_cpu = 1; free_cyc = 0; ce_cyc = -1; cap_cyc = -1; dlv_cyc = -1;
      for (int i = 0; i < 3; i++) e_rd[i] = '0;
      sa_d = 0; sa_s = 0; sa_c = 0;
    end else begin
      e_err = p0 && seen && ((cyc - last_p0) % 5 != 0);
      win = -1;
      if (p0 && cyc >= free_cyc) begin
        if (disp_req) win = 0;
        else if (cpu_req && (rr_cpu || !spr_req)) win = 2;
        else if (spr_req) win = 1;
      end
      if (win >= 0) begin
        m_own   = win;
        ce_cyc  = cyc + 1;
        e_addr  = (win == 0) ? disp_addr : (win == 1) ? spr_addr : cpu_addr;
        e_we    = (win == 2) && cpu_we;
        e_wdata = e_we ? cpu_wdata : '0;
        if (e_we) free_cyc = cyc + 2;
        else begin
          cap_cyc  = cyc + 1 + RDL;
          dlv_cyc  = cyc + 2 + RDL;
          free_cyc = cyc + 3 + RDL;
        end
        if (win == 2) rr_cpu = 0;
        if (win == 1) rr_cpu = 1;
      end
      chk("acks", {d_ack, s_ack, c_ack}, {win == 0, win == 1, win == 2});
      chk("phase_err", p_err, e_err);
      e_ce = (cyc == ce_cyc);
      chk("mem_port", {m_ce, m_we, m_ad, m_wd},
          e_ce ? {1'b1, e_we, e_addr, e_wdata} : '0);
      e_rv = 3'b000;
      if (cyc == dlv_cyc) begin
        e_rd[m_own] = cap_data;
        e_rv[2 - m_own] = 1'b1;
      end
      chk("rvalids", {d_rv, s_rv, c_rv}, e_rv);
      chk("rdata", {d_rd, s_rd, c_rd}, {e_rd[0], e_rd[1], e_rd[2]});
      if (cyc == cap_cyc) cap_data = mem_rdata;
      if (p0) begin seen = 1; last_p0 = cyc; end
      sa_d = d_ack; sa_s = s_ack; sa_c = c_ack;
    end
    cyc++;
  end

  // ---------------- stimulus
  task automatic rnd_req();
    if (sa_d) disp_req = 0;
    else if (!disp_req && $urandom_range(7) == 0) begin disp_req = 1; disp_addr = AW'($urandom); end
    else if (disp_req && $urandom_range(39) == 0) disp_req = 0;
    if (sa_s) spr_req = 0;
    else if (!spr_req && $urandom_range(3) == 0) begin spr_req = 1; spr_addr = AW'($urandom); end
    else if (spr_req && $urandom_range(39) == 0) spr_req = 0;
    if (sa_c) cpu_req = 0;
    else if (!cpu_req && $urandom_range(3) == 0) begin
      cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
    end else if (cpu_req && $urandom_range(39) == 0) cpu_req = 0;
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick(input logic ph0);
    @(posedge clk); #1;
    p0 = ph0;
    if (rnd_rdata) mem_rdata = DW'($urandom);
    if (rnd) rnd_req();
  endtask

  task automatic do_reset();
    rst_n = 0; tick(0); tick(0); rst_n = 1;
  endtask

  initial begin : drv
    int exp_seq[7];
    int code, plen;
    exp_seq = '{0, 0, 0, 2, 1, 2, 1};

    // 1: CPU read 0x0123 returning 0xA5
    tick(0); tick(0); rst_n = 1;
    rnd_rdata = 0; mem_rdata = 8'hA5;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0123;
    tick(1); #3 chk("t1_ack", {d_ack, s_ack, c_ack}, 3'b001);
    tick(0); cpu_req = 0;
    #3 chk("t1_ce", {m_ce, m_we, m_ad}, {2'b10, 14'h0123});
    tick(0); tick(0); tick(0);
    #3 chk("t1_rvalid", {c_rv, c_rd}, {1'b1, 8'hA5});
    rnd_rdata = 1;

    // 3: CPU write 0x3FFF <- 0x5A, no rvalid
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h3FFF; cpu_wdata = 8'h5A;
    tick(1); #3 chk("t3_ack", c_ack, 1'b1);
    tick(0); cpu_req = 0;
    #3 chk("t3_ce", {m_ce, m_we, m_ad, m_wd}, {2'b11, 14'h3FFF, 8'h5A});
    for (int i = 0; i < 3; i++) begin tick(0); #3 chk("t3_no_rvalid", c_rv, 1'b0); end

    // 2: priority and round-robin, from reset (CPU first)
    do_reset();
    disp_req = 1; spr_req = 1; cpu_req = 1; cpu_we = 0;
    disp_addr = 14'h0010; spr_addr = 14'h0020; cpu_addr = 14'h0030;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      #3 code = d_ack ? 0 : s_ack ? 1 : c_ack ? 2 : 3;
      chk("t2_winner", code, exp_seq[k]);
      tick(0);
      if (k == 2) disp_req = 0;
      tick(0); tick(0); tick(0);
    end
    spr_req = 0; cpu_req = 0;

    // 4: phase-0 two cycles early while idle -> error and grant there
    tick(1); tick(0); tick(0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0555;
    tick(1); #3 chk("t4_err_ack", {p_err, c_ack}, 2'b11);
    tick(0); cpu_req = 0;
    tick(0); tick(0); tick(0);
    tick(1); #3 chk("t4_resync", p_err, 1'b0);
    tick(0); tick(0); tick(0); tick(0);

    // 6: late requests wait for phase 0; dropped request has no effect
    tick(1);
    tick(0); cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0AAA;
    #3 chk("t6_ph1", {d_ack, s_ack, c_ack}, 3'b000);
    tick(0); spr_req = 1; spr_addr = 14'h0BBB;
    #3 chk("t6_ph2", {s_ack, c_ack}, 2'b00);
    tick(0); cpu_req = 0;
    tick(0); #3 chk("t6_ph4", {s_ack, c_ack, m_ce}, 3'b000);
    tick(1); #3 chk("t6_ack", {s_ack, c_ack}, 2'b10);
    tick(0); spr_req = 0;
    #3 chk("t6_ce", {m_ce, m_ad}, {1'b1, 14'h0BBB});
    tick(0); tick(0); tick(0);

    // 5: reset one cycle after a read strobe
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0777;
    tick(1); tick(0); cpu_req = 0;
    #3 chk("t5_ce", m_ce, 1'b1);
    tick(0); rst_n = 0;
    #3 chk("t5_zero", all_out(), 64'd0);
    tick(0); rst_n = 1;
    disp_req = 1; disp_addr = 14'h0101;
    for (int i = 0; i < 6; i++) begin
      tick(0); #3 chk("t5_no_ack", {d_ack, s_ack, c_ack, c_rv}, 4'b0000);
    end
    tick(1); #3 chk("t5_fresh_ack", d_ack, 1'b1);
    tick(0); disp_req = 0;
    tick(0); tick(0); tick(0);

    // randomized traffic with occasional phase disturbances
    rnd = 1;
    for (int per = 0; per < 400; per++) begin
      plen = ($urandom_range(14) == 0) ? int'($urandom_range(8, 2)) : 5;
      tick(1);
      for (int j = 1; j < plen; j++) tick(0);
    end
    rnd = 0;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
